noc_rr_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one NoC output link among NUM_IN input FIFOs. It watches each FIFO's empty flag and grants one FIFO at a time for exactly PKT_LEN words. It drives that FIFO's read strobe and forwards the words to the downstream link while honouring downstream backpressure. It sits between the per-port input FIFOs and the router output register/link.

---
 rtl/noc_rr_arbiter.sv | 107 ++++++++++
 tb/tb_noc_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC output link among NUM_IN input FIFOs.
// A granted FIFO keeps the link for exactly PKT_LEN words, throttled by downstream backpressure.
module noc_rr_arbiter #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned IDXW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       fifo_empty_i,
    input  logic [NUM_IN*WIDTH-1:0] fifo_data_i,
    output logic [NUM_IN-1:0]       fifo_read_o,
    input  logic                    out_full_i,
    input  logic                    out_afull_i,
    output logic                    out_write_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [IDXW-1:0]         grant_idx_o,
    output logic                    busy_o
);

    localparam int unsigned       CNTW    = $clog2(PKT_LEN) + 1;
    localparam logic [CNTW-1:0]   CntLast = CNTW'(PKT_LEN - 1);
    localparam logic [IDXW-1:0]   LastRst = IDXW'(NUM_IN - 1);
    localparam logic [NUM_IN-1:0] OneHot0 = NUM_IN'(1);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e            state_q;
    logic [IDXW-1:0]   grant_q;
    logic [IDXW-1:0]   last_q;
    logic [CNTW-1:0]   cnt_q;
    logic [IDXW-1:0]   out_sel_q;
    logic              out_write_q;

    logic [NUM_IN-1:0] req;
    logic [IDXW-1:0]   pick;
    logic              found;
    logic              rd_en;

    assign req = ~fifo_empty_i;

    // Two passes: indices above last_q first, then wrap around to indices at or below it.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int unsigned c = 0; c < NUM_IN; c++) begin
            if (!found && req[c] && (IDXW'(c) > last_q)) begin
                pick  = IDXW'(c);
                found = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NUM_IN; c++) begin
            if (!found && req[c] && (IDXW'(c) <= last_q)) begin
                pick  = IDXW'(c);
                found = 1'b1;
            end
        end
    end

    // Gating on almost-full guarantees a slot for the single word in flight.
    assign rd_en = (state_q == StXfer) & ~fifo_empty_i[grant_q] & ~out_full_i & ~out_afull_i;

    assign fifo_read_o = rd_en ? (OneHot0 << grant_q) : '0;
    assign out_data_o  = fifo_data_i[out_sel_q*WIDTH +: WIDTH];
    assign out_write_o = out_write_q;
    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q == StXfer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= LastRst;
            cnt_q       <= '0;
            out_sel_q   <= '0;
            out_write_q <= 1'b0;
        end else begin
            out_write_q <= rd_en;
            if (rd_en) begin
                out_sel_q <= grant_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (rd_en) begin
                        if (cnt_q == CntLast) begin
                            last_q  <= grant_q;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed self-checking bench for noc_rr_arbiter with behavioural input FIFOs.
// Expected grants and words are hand-derived from the arbitration and timing rules.
module tb_noc_rr_arbiter;

    localparam int unsigned NUM_IN  = 4;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned IDXW    = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_IN-1:0]       fifo_empty;
    logic [NUM_IN*WIDTH-1:0] fifo_data;
    logic [NUM_IN-1:0]       fifo_read;
    logic                    out_full = 1'b0;
    logic                    out_afull = 1'b0;
    logic                    out_write;
    logic [WIDTH-1:0]        out_data;
    logic [IDXW-1:0]         grant_idx;
    logic                    busy;

    noc_rr_arbiter #(
        .NUM_IN  (NUM_IN),
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN),
        .IDXW    (IDXW)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_read_o  (fifo_read),
        .out_full_i   (out_full),
        .out_afull_i  (out_afull),
        .out_write_o  (out_write),
        .out_data_o   (out_data),
        .grant_idx_o  (grant_idx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFOs: data appears the cycle after the read strobe.
    logic [15:0] mem    [NUM_IN][256];
    logic [7:0]  rd_ptr [NUM_IN] = '{default: 8'd0};
    logic [7:0]  wr_ptr [NUM_IN] = '{default: 8'd0};
    logic [15:0] data_q [NUM_IN] = '{default: 16'd0};

    always @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (fifo_read[i]) begin
                data_q[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 8'd1;
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            fifo_empty[i]              = (rd_ptr[i] == wr_ptr[i]);
            fifo_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    // Monitor samples 2 time units after the rising edge.
    logic [15:0] wr_log [$];
    int          grant_log [$];
    logic        busy_prev = 1'b0;

    always @(posedge clk) begin
        #2;
        if (!reset && out_write) wr_log.push_back(out_data);
        if (busy && !busy_prev) grant_log.push_back(int'(grant_idx));
        busy_prev = busy;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int f, input logic [15:0] v);
        mem[f][wr_ptr[f]] = v;
        wr_ptr[f] = wr_ptr[f] + 8'd1;
    endtask

    // Leaves reset asserted at a falling edge with all FIFOs emptied.
    task automatic start_test();
        reset     = 1'b1;
        out_afull = 1'b0;
        out_full  = 1'b0;
        @(negedge clk);
        for (int f = 0; f < NUM_IN; f++) wr_ptr[f] = rd_ptr[f];
    endtask

    task automatic check_words(input string tag, input int base, input int n,
                               input int f, input int first, input logic [15:0] tagv);
        for (int j = 0; j < n; j++) begin
            check_eq($sformatf("%s_w%0d", tag, j), 32'(wr_log[base+j]),
                     32'(tagv + 16'(f*256 + first + j)));
        end
    endtask

    initial begin
        int w0;
        int g0;

        // Reset state, with a requester present.
        start_test();
        push(1, 16'h0000);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_write", 32'(out_write), 32'd0);
        check_eq("rst_read", 32'(fifo_read), 32'd0);
        check_eq("rst_grant", 32'(grant_idx), 32'd0);

        // Test 1: single FIFO 2 with A0..A3.
        start_test();
        for (int j = 0; j < 4; j++) push(2, 16'hA200 + 16'(j));
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("t1_grant_c%0d", k+1), 32'(grant_idx), 32'd2);
            check_eq($sformatf("t1_busy_c%0d", k+1), 32'(busy), (k < 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("t1_read_c%0d", k+1), 32'(fifo_read),
                     (k < 4) ? 32'h4 : 32'h0);
            check_eq($sformatf("t1_write_c%0d", k+1), 32'(out_write),
                     (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 4)
                check_eq($sformatf("t1_data_c%0d", k+1), 32'(out_data),
                         32'(16'hA200 + 16'(k-1)));
        end

        // Test 2: all FIFOs with 8 words, back-to-back packets.
        start_test();
        for (int f = 0; f < NUM_IN; f++)
            for (int j = 0; j < 8; j++) push(f, 16'h2000 + 16'(f*256 + j));
        w0 = wr_log.size();
        g0 = grant_log.size();
        reset = 1'b0;
        repeat (39) @(negedge clk);
        check_eq("t2_writes_39", 32'(wr_log.size() - w0), 32'd31);
        @(negedge clk);
        check_eq("t2_writes_40", 32'(wr_log.size() - w0), 32'd32);
        check_eq("t2_busy_end", 32'(busy), 32'd0);
        check_eq("t2_npkts", 32'(grant_log.size() - g0), 32'd8);
        for (int p = 0; p < 8; p++) begin
            check_eq($sformatf("t2_grant%0d", p), 32'(grant_log[g0+p]), 32'(p % 4));
            check_words($sformatf("t2_p%0d", p), w0 + p*4, 4, p % 4, (p / 4) * 4, 16'h2000);
        end

        // Test 3: FIFO 1 runs dry after 2 words, refills later.
        start_test();
        push(1, 16'h3100);
        push(1, 16'h3101);
        for (int j = 0; j < 4; j++) push(2, 16'h3200 + 16'(j));
        w0 = wr_log.size();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t3_grant", 32'(grant_idx), 32'd1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("t3_stall_read%0d", k), 32'(fifo_read), 32'h0);
            check_eq($sformatf("t3_stall_grant%0d", k), 32'(grant_idx), 32'd1);
            check_eq($sformatf("t3_stall_busy%0d", k), 32'(busy), 32'd1);
        end
        push(1, 16'h3102);
        push(1, 16'h3103);
        @(negedge clk);
        check_eq("t3_refill_read", 32'(fifo_read), 32'h2);
        @(negedge clk);
        check_eq("t3_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("t3_next_grant", 32'(grant_idx), 32'd2);
        check_eq("t3_nwords", 32'(wr_log.size() - w0), 32'd4);
        check_words("t3", w0, 4, 1, 0, 16'h3000);

        // Test 4: almost-full for 3 cycles mid-packet.
        start_test();
        for (int j = 0; j < 4; j++) push(0, 16'h4000 + 16'(j));
        w0 = wr_log.size();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        out_afull = 1'b1;
        #1;
        check_eq("t4_afull_read0", 32'(fifo_read), 32'h0);
        @(negedge clk);
        check_eq("t4_afull_read1", 32'(fifo_read), 32'h0);
        check_eq("t4_afull_write1", 32'(out_write), 32'd0);
        @(negedge clk);
        check_eq("t4_afull_read2", 32'(fifo_read), 32'h0);
        @(negedge clk);
        check_eq("t4_afull_busy", 32'(busy), 32'd1);
        out_afull = 1'b0;
        #1;
        check_eq("t4_resume_read", 32'(fifo_read), 32'h1);
        @(negedge clk);
        check_eq("t4_write_d2", 32'(out_data), 32'h4002);
        @(negedge clk);
        check_eq("t4_write_d3", 32'(out_data), 32'h4003);
        check_eq("t4_busy_end", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t4_nwords", 32'(wr_log.size() - w0), 32'd4);
        check_words("t4", w0, 4, 0, 0, 16'h4000);

        // Test 5: reset during a packet from FIFO 3.
        start_test();
        for (int j = 0; j < 4; j++) push(3, 16'h5300 + 16'(j));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5_pre_read", 32'(fifo_read), 32'h8);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_read", 32'(fifo_read), 32'h0);
        check_eq("t5_rst_write", 32'(out_write), 32'd0);
        check_eq("t5_rst_grant", 32'(grant_idx), 32'd0);
        for (int j = 0; j < 4; j++) push(0, 16'h5000 + 16'(j));
        @(negedge clk);
        w0 = wr_log.size();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_grant0", 32'(grant_idx), 32'd0);
        repeat (7) @(negedge clk);
        check_eq("t5_nwords", 32'(wr_log.size() - w0), 32'd6);
        check_words("t5_f0", w0, 4, 0, 0, 16'h5000);
        check_words("t5_f3", w0 + 4, 2, 3, 2, 16'h5000);

        // Test 6: FIFOs 0 and 3 alternate once FIFO 0 has been served.
        start_test();
        for (int j = 0; j < 12; j++) push(0, 16'h6000 + 16'(j));
        g0 = grant_log.size();
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) push(3, 16'h6300 + 16'(j));
        repeat (30) @(negedge clk);
        check_eq("t6_npkts", 32'(grant_log.size() - g0), 32'd5);
        for (int p = 0; p < 5; p++)
            check_eq($sformatf("t6_grant%0d", p), 32'(grant_log[g0+p]),
                     (p % 2 == 0) ? 32'd0 : 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
